// File: rtl/radar_pkg.sv
// Shared types and constants for the radar target emulator.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package radar_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    MEASURE = 2'b01,
    DELAY   = 2'b10,
    ECHO    = 2'b11
  } emu_state_t;

  // Metres of range per microsecond of round-trip time at c = 3e8 m/s.
  localparam int unsigned C_M_PER_RT_US = 150;
  // Default radar listening window in cycles.
  localparam int unsigned C_MAX_DELAY   = 2000;
  localparam int unsigned C_RANGE_W     = 32;

  typedef logic [C_RANGE_W-1:0] range_t;

endpackage

// File: rtl/range_divider.sv
// Sequential restoring divider of a 32-bit range by the constant 150.
// Latency: done pulses 32 cycles after the start edge; quotient holds until the next start.
// Backpressure: none; a start while busy restarts the division with the new dividend.
module range_divider
  import radar_pkg::*;
(
  input  logic   CLK,
  input  logic   RST_N,
  input  logic   start,
  input  range_t dividend,
  output range_t quotient,
  output logic   done,
  output logic   busy
);

  localparam logic [8:0] DIVISOR = 9'(C_M_PER_RT_US);

  // Remainder is always below 150, so 8 bits hold it; the shifted trial needs 9.
  logic [7:0] rem;
  logic [5:0] step;
  range_t     q;
  logic [8:0] trial;
  logic       take;
  logic [7:0] diff;

  assign trial    = {rem, q[C_RANGE_W-1]};
  assign take     = (trial >= DIVISOR);
  assign diff     = trial[7:0] - DIVISOR[7:0];
  assign quotient = q;

  // One quotient bit per cycle: shift the dividend MSB into the remainder and subtract when it fits.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      q    <= '0;
      rem  <= '0;
      step <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        q    <= dividend;
        rem  <= '0;
        step <= 6'd32;
        busy <= 1'b1;
      end else if (busy) begin
        q    <= {q[C_RANGE_W-2:0], take};
        rem  <= take ? diff : trial[7:0];
        step <= step - 6'd1;
        if (step == 6'd1) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/radar_target_emulator.sv
// Far-end target model: measures a radar trigger pulse and returns an echo after the range round-trip delay.
// Latency: echo rises max(range/150,1) cycles after the edge that first samples the trigger low.
// Backpressure: none; triggers arriving while an echo is pending or being sent are ignored.
module radar_target_emulator
  import radar_pkg::*;
#(
  parameter int unsigned MIN_PULSE  = 40,
  parameter int unsigned MAX_DELAY  = C_MAX_DELAY,
  parameter int unsigned ECHO_WIDTH = 4,
  parameter int unsigned UM_PER_M   = 1000000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        radar_pulse_trigger,
  input  logic        target_present,
  input  logic        load,
  input  logic [31:0] init_range,
  input  logic [31:0] closing_speed,
  output logic        radar_echo,
  output logic [31:0] current_range,
  output logic [15:0] echo_count,
  output logic [15:0] reject_count,
  output logic [1:0]  emu_state
);

  localparam logic [15:0] MIN_W     = 16'(MIN_PULSE);
  localparam range_t      MAX_D     = 32'(MAX_DELAY);
  localparam logic [15:0] ECHO_LAST = 16'(ECHO_WIDTH - 1);
  localparam logic [31:0] UM        = 32'(UM_PER_M);

  emu_state_t  state;
  range_t      range_q;
  logic [31:0] acc;
  logic [31:0] acc_sum;
  logic        trig_prev;
  logic [15:0] width_cnt;
  logic [15:0] dly_cnt;
  logic [15:0] ecnt;
  logic        div_start;
  logic        div_done;
  logic        div_busy;
  logic        div_ready;
  range_t      div_q;

  // Both addends stay below UM_PER_M, so the sum cannot overflow 32 bits.
  assign acc_sum       = acc + closing_speed;
  assign current_range = range_q;
  assign emu_state     = state;

  // A pulse starts only on a fresh 0->1 sample seen while idle; the divider takes the range at that edge.
  assign div_start = (state == IDLE) && radar_pulse_trigger && !trig_prev;

  range_divider u_div (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .start    (div_start),
    .dividend (range_q),
    .quotient (div_q),
    .done     (div_done),
    .busy     (div_busy)
  );

  // Integrate closing speed in micrometres per microsecond; load overrides and restarts the fraction.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      range_q <= '0;
      acc     <= '0;
    end else if (load) begin
      range_q <= init_range;
      acc     <= '0;
    end else if (acc_sum >= UM) begin
      acc <= acc_sum - UM;
      if (range_q != '0) range_q <= range_q - 32'd1;
    end else begin
      acc <= acc_sum;
    end
  end

  // Pulse measurement, echo delay and echo generation with registered outputs and counters.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= IDLE;
      trig_prev    <= 1'b0;
      width_cnt    <= '0;
      dly_cnt      <= '0;
      ecnt         <= '0;
      div_ready    <= 1'b0;
      radar_echo   <= 1'b0;
      echo_count   <= '0;
      reject_count <= '0;
    end else begin
      trig_prev <= radar_pulse_trigger;
      if (div_start)     div_ready <= 1'b0;
      else if (div_done) div_ready <= 1'b1;

      case (state)
        IDLE: begin
          if (div_start) begin
            width_cnt <= '0;
            state     <= MEASURE;
          end
        end
        MEASURE: begin
          if (radar_pulse_trigger) begin
            if (width_cnt != 16'hFFFF) width_cnt <= width_cnt + 16'd1;
          end else if ((width_cnt < MIN_W) || (div_q > MAX_D)) begin
            reject_count <= reject_count + 16'd1;
            state        <= IDLE;
          end else begin
            // A zero-range target still needs one cycle of delay before the echo.
            dly_cnt <= (div_q == '0) ? 16'd1 : div_q[15:0];
            state   <= DELAY;
          end
        end
        DELAY: begin
          if (dly_cnt == 16'd1) begin
            if (target_present) begin
              radar_echo <= 1'b1;
              echo_count <= echo_count + 16'd1;
              ecnt       <= ECHO_LAST;
              state      <= ECHO;
            end else begin
              state <= IDLE;
            end
          end else begin
            dly_cnt <= dly_cnt - 16'd1;
          end
        end
        ECHO: begin
          if (ecnt == '0) begin
            radar_echo <= 1'b0;
            state      <= IDLE;
          end else begin
            ecnt <= ecnt - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The quotient must be settled before a full-width pulse ends, since that edge consumes it.
  assert property (@(posedge CLK) disable iff (!RST_N)
    (state == MEASURE && !radar_pulse_trigger && width_cnt >= MIN_W) |-> (div_ready && !div_busy));

endmodule

// File: tb/tb_radar_target_emulator.sv
// Self-checking bench for radar_target_emulator: vector table plus corner-case sequences.
// Latency: echo rise cycles are predicted per pulse and matched against observed rises.
// Backpressure: not applicable; the bench drives the pulse wire directly.
module tb_radar_target_emulator;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        radar_pulse_trigger = 1'b0;
  logic        target_present = 1'b1;
  logic        load = 1'b0;
  logic [31:0] init_range = '0;
  logic [31:0] closing_speed = '0;
  logic        radar_echo;
  logic [31:0] current_range;
  logic [15:0] echo_count;
  logic [15:0] reject_count;
  logic [1:0]  emu_state;

  radar_target_emulator dut (
    .CLK                 (CLK),
    .RST_N               (RST_N),
    .radar_pulse_trigger (radar_pulse_trigger),
    .target_present      (target_present),
    .load                (load),
    .init_range          (init_range),
    .closing_speed       (closing_speed),
    .radar_echo          (radar_echo),
    .current_range       (current_range),
    .echo_count          (echo_count),
    .reject_count        (reject_count),
    .emu_state           (emu_state)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int exp_rise[$];
  int obs_rise[$];
  int obs_width[$];
  logic echo_prev = 1'b0;
  int   hi_cnt = 0;

  // Record every echo rise (cycle of the rising edge) and its high width.
  always @(negedge CLK) begin
    if (radar_echo && !echo_prev) begin
      obs_rise.push_back(cyc);
      hi_cnt <= 1;
    end else if (radar_echo) begin
      hi_cnt <= hi_cnt + 1;
    end else if (echo_prev) begin
      obs_width.push_back(hi_cnt);
    end
    echo_prev <= radar_echo;
  end

  int n_cmp = 0;
  int n_fail = 0;
  int exp_ecnt = 0;
  int exp_rcnt = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic miss(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  task automatic load_range(input logic [31:0] r, input logic [31:0] s);
    @(negedge CLK);
    init_range    = r;
    closing_speed = s;
    load          = 1'b1;
    @(negedge CLK);
    load = 1'b0;
  endtask

  // Drive the trigger high for hi sampled edges; e is the first edge that samples it low.
  task automatic pulse(input int hi, output int e);
    @(negedge CLK);
    radar_pulse_trigger = 1'b1;
    repeat (hi) @(negedge CLK);
    radar_pulse_trigger = 1'b0;
    e = cyc + 1;
  endtask

  task automatic settle(input string tag);
    int n;
    int e;
    n = 0;
    while (emu_state != 2'd0 && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 3000) miss($sformatf("%s.idle_timeout state=%0d", tag, emu_state));
    repeat (3) @(negedge CLK);
    while (exp_rise.size() > 0) begin
      e = exp_rise.pop_front();
      if (obs_rise.size() > 0) check($sformatf("%s.rise_cycle", tag), obs_rise.pop_front(), e);
      else miss($sformatf("%s.missing_echo expected at cycle %0d", tag, e));
      if (obs_width.size() > 0) check($sformatf("%s.echo_width", tag), obs_width.pop_front(), 4);
      else miss($sformatf("%s.echo_width not observed", tag));
    end
    while (obs_rise.size() > 0) miss($sformatf("%s.unexpected_echo at cycle %0d", tag, obs_rise.pop_front()));
    obs_width.delete();
    check($sformatf("%s.echo_count", tag), echo_count, exp_ecnt & 16'hFFFF);
    check($sformatf("%s.reject_count", tag), reject_count, exp_rcnt & 16'hFFFF);
  endtask

  task automatic check_reset_outputs(input string tag);
    check($sformatf("%s.radar_echo", tag), radar_echo, 0);
    check($sformatf("%s.current_range", tag), current_range, 0);
    check($sformatf("%s.echo_count", tag), echo_count, 0);
    check($sformatf("%s.reject_count", tag), reject_count, 0);
    check($sformatf("%s.emu_state", tag), emu_state, 0);
  endtask

  typedef struct {
    logic [31:0] rng;
    logic [31:0] spd;
    bit          present;
    int          hi;
    bit          echo;
    int          delay;
    int          rej;
    int          st_e;
  } vec_t;

  vec_t vt[8];

  initial begin
    int e;

    //         range         speed present hi  echo delay rej state@E
    vt[0] = '{32'd1500,      32'd0, 1'b1, 300, 1'b1, 10,   0, 2};
    vt[1] = '{32'd300000,    32'd0, 1'b1, 60,  1'b1, 2000, 0, 2};
    vt[2] = '{32'd300150,    32'd0, 1'b1, 60,  1'b0, 0,    1, 0};
    vt[3] = '{32'd1500,      32'd0, 1'b1, 20,  1'b0, 0,    1, 0};
    vt[4] = '{32'd0,         32'd0, 1'b1, 60,  1'b1, 1,    0, 2};
    vt[5] = '{32'd449,       32'd0, 1'b1, 45,  1'b1, 2,    0, 2};
    vt[6] = '{32'd1500,      32'd0, 1'b0, 60,  1'b0, 0,    0, 2};
    vt[7] = '{32'hFFFFFFFF,  32'd0, 1'b1, 60,  1'b0, 0,    1, 0};

    repeat (3) @(negedge CLK);
    check_reset_outputs("reset");
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);

    for (int i = 0; i < 8; i++) begin
      load_range(vt[i].rng, vt[i].spd);
      target_present = vt[i].present;
      pulse(vt[i].hi, e);
      if (vt[i].echo) begin
        exp_rise.push_back(e + vt[i].delay);
        exp_ecnt++;
      end
      exp_rcnt += vt[i].rej;
      @(negedge CLK);
      check($sformatf("vec%0d.state_at_E", i), emu_state, vt[i].st_e);
      settle($sformatf("vec%0d", i));
      target_present = 1'b1;
    end

    // Closing target: two cycles per metre at 500000 um/us.
    load_range(32'd3000, 32'd500000);
    repeat (200) @(negedge CLK);
    check("closing.current_range", current_range, 2900);
    pulse(60, e);
    exp_rise.push_back(e + 19);
    exp_ecnt++;
    @(negedge CLK);
    check("closing.state_at_E", emu_state, 2);
    settle("closing");

    // Second trigger while the first pulse's echo is pending.
    load_range(32'd1500, 32'd0);
    pulse(60, e);
    exp_rise.push_back(e + 10);
    exp_ecnt++;
    repeat (3) @(negedge CLK);
    radar_pulse_trigger = 1'b1;
    repeat (3) @(negedge CLK);
    radar_pulse_trigger = 1'b0;
    settle("retrigger");

    // Reset five cycles into the delay drops the echo in flight.
    load_range(32'd1500, 32'd0);
    pulse(60, e);
    repeat (6) @(negedge CLK);
    check("rst_mid.delay_state", emu_state, 2);
    RST_N = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    exp_ecnt = 0;
    exp_rcnt = 0;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    repeat (30) @(negedge CLK);
    check("rst_mid.no_echo_after_reset", obs_rise.size(), 0);
    obs_rise.delete();
    obs_width.delete();
    load_range(32'd1500, 32'd0);
    pulse(60, e);
    exp_rise.push_back(e + 10);
    exp_ecnt++;
    settle("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
